// File: rtl/menu_overlay_pkg.sv
// menu_overlay_pkg
// Shared definitions for the menu window overlay: coordinate widths,
// configuration field codes and the power-on geometry of window 0.
package menu_overlay_pkg;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   typedef enum logic [2:0] {
      FLD_XLO = 3'd0,
      FLD_XHI = 3'd1,
      FLD_YLO = 3'd2,
      FLD_YHI = 3'd3,
      FLD_EN  = 3'd4
   } field_e;

   typedef struct packed {
      logic [X_W-1:0] x_lo;
      logic [X_W-1:0] x_hi;
      logic [Y_W-1:0] y_lo;
      logic [Y_W-1:0] y_hi;
      logic           en;
   } geom_t;

   localparam logic [X_W-1:0] WIN0_X_LO = 11'd5;
   localparam logic [X_W-1:0] WIN0_X_HI = 11'd596;
   localparam logic [Y_W-1:0] WIN0_Y_LO = 10'd96;
   localparam logic [Y_W-1:0] WIN0_Y_HI = 10'd381;

   localparam geom_t WIN0_DEFAULT = '{
      x_lo: WIN0_X_LO, x_hi: WIN0_X_HI,
      y_lo: WIN0_Y_LO, y_hi: WIN0_Y_HI,
      en:   1'b1
   };

endpackage

// File: rtl/menu_window_hit.sv
// menu_window_hit
// One overlay window: shadow and active geometry registers plus the
// registered (stage-1) hit and border bits for the current raster position.
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   we, field, data   decoded shadow write for this window
//   frame_start       copies shadow (including a same-cycle write) to active
//   gr_x, gr_y        raster coordinate
//   hit, border       stage-1 registered results
module menu_window_hit
   import menu_overlay_pkg::*;
#(
   parameter int BORDER     = 3,
   parameter bit IS_DEFAULT = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           we,
   input  logic [2:0]     field,
   input  logic [X_W-1:0] data,
   input  logic           frame_start,
   input  logic [X_W-1:0] gr_x,
   input  logic [Y_W-1:0] gr_y,
   output logic           hit,
   output logic           border
);

   localparam geom_t          RST_GEOM = IS_DEFAULT ? WIN0_DEFAULT : '0;
   localparam logic [X_W-1:0] BORDER_X = X_W'(BORDER);
   localparam logic [Y_W-1:0] BORDER_Y = Y_W'(BORDER);

   geom_t shadow, shadow_next, active;
   logic  hit_c, border_c;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      shadow_next = shadow;
      if (we) begin
         case (field)
            FLD_XLO: shadow_next.x_lo = data;
            FLD_XHI: shadow_next.x_hi = data;
            FLD_YLO: shadow_next.y_lo = data[Y_W-1:0];
            FLD_YHI: shadow_next.y_hi = data[Y_W-1:0];
            FLD_EN:  shadow_next.en   = data[0];
            default: ;
         endcase
      end
   end

   // Inverted bounds simply fail one of the two inclusive compares.
   // The differences are only meaningful inside the hit region, where they
   // cannot underflow; outside it the result is masked by hit_c.
   always_comb begin
      hit_c = active.en &&
              (gr_x >= active.x_lo) && (gr_x <= active.x_hi) &&
              (gr_y >= active.y_lo) && (gr_y <= active.y_hi);
      border_c = hit_c &&
                 (((gr_x - active.x_lo) < BORDER_X) ||
                  ((active.x_hi - gr_x) < BORDER_X) ||
                  ((gr_y - active.y_lo) < BORDER_Y) ||
                  ((active.y_hi - gr_y) < BORDER_Y));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= RST_GEOM;
         active <= RST_GEOM;
         hit    <= 1'b0;
         border <= 1'b0;
      end else begin
         shadow <= shadow_next;
         if (frame_start) active <= shadow_next;
         hit    <= hit_c;
         border <= border_c;
      end
   end

endmodule

// File: rtl/menu_window_overlay.sv
// menu_window_overlay
// Menu overlay generator: N_WIN double-buffered rectangular windows checked
// against the raster position, lowest index wins. Two-stage pipeline.
// Ports:
//   clk, reset                     pixel clock, synchronous active-high reset
//   enable                         overlay enable, pipelined with coordinates
//   gr_x, gr_y                     raster coordinate
//   frame_start                    commits geometry, advances blink counter
//   cfg_we/idx/field/data          shadow register write port
//   sel_valid, sel_idx             selection highlight request
//   out_bg, out_frame, out_sel     fill, border, blinking highlight flags
//   out_id                         winning window (0 when out_bg = 0)
module menu_window_overlay
   import menu_overlay_pkg::*;
#(
   parameter int N_WIN        = 4,
   parameter int BORDER       = 3,
   parameter int BLINK_FRAMES = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic [X_W-1:0] gr_x,
   input  logic [Y_W-1:0] gr_y,
   input  logic           frame_start,
   input  logic           cfg_we,
   input  logic [2:0]     cfg_idx,
   input  logic [2:0]     cfg_field,
   input  logic [X_W-1:0] cfg_data,
   input  logic           sel_valid,
   input  logic [2:0]     sel_idx,
   output logic           out_bg,
   output logic           out_frame,
   output logic           out_sel,
   output logic [2:0]     out_id
);

   localparam int             CW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_FRAMES - 1);

   logic [N_WIN-1:0] hit_s1, border_s1;
   logic             en_s1;
   logic [CW-1:0]    blink_cnt;
   logic             blink_on;

   // Writes to nonexistent windows match no instance and are dropped.
   for (genvar i = 0; i < N_WIN; i++) begin : g_win
      menu_window_hit #(
         .BORDER     (BORDER),
         .IS_DEFAULT (i == 0)
      ) u_win (
         .clk         (clk),
         .reset       (reset),
         .we          (cfg_we && (cfg_idx == 3'(i))),
         .field       (cfg_field),
         .data        (cfg_data),
         .frame_start (frame_start),
         .gr_x        (gr_x),
         .gr_y        (gr_y),
         .hit         (hit_s1[i]),
         .border      (border_s1[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_s1     <= 1'b0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         en_s1 <= enable;
         if (frame_start) begin
            if (blink_cnt == CNT_LAST) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // Priority encoder: scan from the top so the lowest hitting index is the
   // last one assigned and therefore wins.
   logic       any_hit, win_border;
   logic [2:0] win;
   logic       bg_n, frame_n, sel_n;

   always_comb begin
      any_hit    = 1'b0;
      win_border = 1'b0;
      win        = '0;
      for (int i = N_WIN - 1; i >= 0; i--) begin
         if (hit_s1[i]) begin
            any_hit    = 1'b1;
            win_border = border_s1[i];
            win        = 3'(i);
         end
      end
      bg_n    = en_s1 && any_hit;
      frame_n = bg_n && win_border;
      // win is always < N_WIN, so an out-of-range sel_idx never matches.
      sel_n   = frame_n && sel_valid && (win == sel_idx) && blink_on;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_bg    <= 1'b0;
         out_frame <= 1'b0;
         out_sel   <= 1'b0;
         out_id    <= '0;
      end else begin
         out_bg    <= bg_n;
         out_frame <= frame_n;
         out_sel   <= sel_n;
         out_id    <= bg_n ? win : 3'd0;
      end
   end

endmodule

// File: doc/menu_window_overlay.md
# menu_window_overlay

Parametrised menu overlay generator for the VGA output path. It evaluates up to N_WIN runtime-programmable rectangular windows against the current raster coordinate. For each pixel it produces a fill flag, a border flag, a blinking selection-highlight flag and the winning window index. Window geometry is double-buffered and committed at frame start, so menu moves never tear mid-frame. The outputs feed the pixel colour mux alongside the other graphic layers.

## Interface
Parameters:
- N_WIN, 4, number of windows (1..8)
- BORDER, 3, border thickness in pixels (≥1)
- BLINK_FRAMES, 16, frames per blink half-period (≥1)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  overlay enable; pipelined alongside the coordinates
- gr_x  in  11  current raster x
- gr_y  in  10  current raster y
- frame_start  in  1  one-cycle pulse at start of frame; commits shadow geometry and advances the blink counter
- cfg_we  in  1  shadow register write strobe
- cfg_idx  in  3  window index; writes with cfg_idx ≥ N_WIN are ignored
- cfg_field  in  3  field select: 0 x_lo, 1 x_hi, 2 y_lo, 3 y_hi, 4 en; codes 5..7 are ignored
- cfg_data  in  11  write data; y fields use bits [9:0], en uses bit 0
- sel_valid  in  1  selection highlight active
- sel_idx  in  3  selected window
- out_bg  out  1  pixel lies inside some enabled window
- out_frame  out  1  pixel lies on the border of the winning window
- out_sel  out  1  pixel lies on the border of the selected window and the blink phase is on
- out_id  out  3  winning window index; 0 when out_bg = 0

## Operation
- Each window has a shadow register set and an active register set: x_lo, x_hi, y_lo, y_hi, en.
- cfg_we writes the shadow set only.
- On frame_start, every active set is loaded from its shadow set.
  - If cfg_we and frame_start coincide, the committed value includes that cycle's write.
- Window hit: en & x_lo ≤ x ≤ x_hi & y_lo ≤ y ≤ y_hi.
  - The comparison is unsigned and inclusive.
  - If x_lo > x_hi or y_lo > y_hi, the window never hits.
- Border: hit & ((x − x_lo) < BORDER | (x_hi − x) < BORDER | (y − y_lo) < BORDER | (y_hi − y) < BORDER).
  - Differences are taken only inside the hit region, so they cannot underflow.
  - A window narrower than 2·BORDER is all border.
- Priority: the lowest-index hitting window wins.
  - out_frame and out_sel reflect the winner only; lower-priority borders are hidden.
- Blink: a frame counter 0..BLINK_FRAMES−1 increments on frame_start. It wraps to 0 and toggles blink_on.
  - out_sel = out_frame & sel_valid & (out_id == sel_idx) & blink_on.
  - sel_idx ≥ N_WIN yields no highlight.
- enable = 0: all outputs are 0 at the normal latency. Registers and counters keep running.
- Reset values:
  - All outputs 0.
  - Window 0 shadow and active = x 5..596, y 96..381, en = 1.
  - All other windows: all fields 0, en = 0.
  - Blink counter 0, blink_on = 1.
- Reset mid-frame takes effect on the next clock. Defaults are active immediately, with no wait for frame_start.

## Timing
- Two-stage pipeline, latency 2 cycles from gr_x/gr_y/enable to all outputs.
  - Stage 1 registers the per-window hit and border bits together with enable.
  - Stage 2 registers the priority-encoded outputs.
- A frame_start in cycle t makes the new geometry affect coordinates presented in cycle t+1. Those results appear at t+3.
- blink_on changes on the clock that consumes frame_start. It applies to stage-2 outputs from the next cycle onward.
- Config writes take one cycle; there is no backpressure.

## Structure
- Package menu_overlay_pkg holds:
  - field codes (FLD_XLO..FLD_EN)
  - the default window-0 geometry constants (5, 596, 96, 381)
  - the coordinate widths (11/10)
- Sub-module menu_window_hit is instantiated N_WIN times.
  - It holds the shadow/active registers for one window.
  - It produces the registered stage-1 hit and border bits.
- The top level does config decode, the blink counter, the priority encoder and stage 2.

## Test plan
- After reset, enable = 1, raster (5,96) → out_bg = 1, out_frame = 1 at +2 cycles. (8,99) → bg = 1, frame = 0. (594,200) → frame = 1. (597,200) → bg = 0.
- Write window 1 = x 100..199, y 150..249, en = 1, without a frame_start → no change. After frame_start, (150,200) still resolves to id 0 (inside window 0). After disabling window 0 → id 1, bg = 1, frame = 0.
- Overlap: windows 0 and 1 both hit (102,200) with window 1's border there → out_id = 0 and frame follows window 0 only (0).
- Blink: BLINK_FRAMES = 2, sel_valid = 1, sel_idx = 0, raster on a window-0 border. Over 8 frame_starts out_sel = 1,1,0,0,1,1,0,0 per frame.
- Degenerate window x_lo = 300, x_hi = 200 → never hits. Write to cfg_idx = 7 with N_WIN = 4 → no register changes.
- enable = 0 on a border pixel → all outputs 0 two cycles later. Reset asserted mid-frame after reprogramming → window-0 defaults restored, out_* = 0 on the next cycle.
